csa_mult_seq: RTL and testbench

Sequential unsigned WIDTH x WIDTH multiplier controller for the ALU multiply path. It reuses a single row of WIDTH csa1 cells over WIDTH cycles instead of a full array, keeping partial sum/carry vectors in registers. One final carry-propagate cycle produces the 2*WIDTH product. Valid/ready handshakes on input and output connect it to the ALU issue and writeback logic.

---
 rtl/csa_mult_pkg.sv | 17 +
 rtl/csa_row.sv | 40 ++++
 rtl/csa_mult_seq.sv | 132 +++++++++++++
 tb/tb_csa_mult_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_mult_pkg.sv
// Shared types and helpers for the sequential carry-save multiplier.
package csa_mult_pkg;

    // Controller states: waiting, one row pass per multiplier bit, final add, result held.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Width of the step counter that walks the multiplier bits 0..width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// One row of carry-save cells, reused by the controller on every accumulate step.

// Single carry-save cell: adds the partial-product bit xi&yi into a sum/carry pair.
module csa1 (
    input  logic xi,
    input  logic yi,
    input  logic sum_in,
    input  logic carry_in,
    output logic sum_out,
    output logic carry_out
);
    logic pp;

    assign pp        = xi & yi;
    assign sum_out   = sum_in ^ pp ^ carry_in;
    assign carry_out = (sum_in & pp) | (sum_in & carry_in) | (pp & carry_in);
endmodule

// WIDTH cells side by side; purely combinational.
module csa_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic             yi,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    output logic [WIDTH-1:0] sum_out,
    output logic [WIDTH-1:0] carry_out
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        csa1 u_cell (
            .xi       (x[i]),
            .yi       (yi),
            .sum_in   (sum_in[i]),
            .carry_in (carry_in[i]),
            .sum_out  (sum_out[i]),
            .carry_out(carry_out[i])
        );
    end
endmodule

// File: rtl/csa_mult_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one carry-save row reused for WIDTH
// steps, then a single carry-propagate cycle builds the upper half of the product.
// The redundant pair (S, C) always represents (a*b - lo) >> step, so S+C fits in WIDTH bits.
module csa_mult_seq
    import csa_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               state_q,   state_d;
    logic [WIDTH-1:0]     a_q,       a_d;
    logic [WIDTH-1:0]     b_q,       b_d;
    logic [WIDTH-1:0]     s_q,       s_d;
    logic [WIDTH-1:0]     c_q,       c_d;
    logic [WIDTH-1:0]     lo_q,      lo_d;
    logic [CNT_W-1:0]     count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     row_sum;
    logic [WIDTH-1:0]     row_carry;
    logic [WIDTH-1:0]     hi_sum;
    logic                 accept;

    csa_row #(.WIDTH(WIDTH)) u_row (
        .x        (a_q),
        .yi       (b_q[count_q]),
        .sum_in   (s_q),
        .carry_in (c_q),
        .sum_out  (row_sum),
        .carry_out(row_carry)
    );

    // Carry-out of this add is zero for any exact product, so only WIDTH bits are kept.
    assign hi_sum = s_q + c_q;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM) || (state_q == RESOLVE);
    assign product   = product_q;

    // Next-state and datapath updates for every register.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a signal
        // unassigned; that is what keeps it from inferring latches.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        c_d       = c_q;
        lo_d      = lo_q;
        count_d   = count_q;
        product_d = product_q;

        if (abort) begin
            // Cancel drops to IDLE and ignores any handshake; the last product is kept.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        a_d     = a;
                        b_d     = b;
                        s_d     = '0;
                        c_d     = '0;
                        count_d = '0;
                        state_d = ACCUM;
                    end else if (state_q == DONE && out_ready) begin
                        state_d = IDLE;
                    end
                end
                ACCUM: begin
                    // Bit 0 of the row sum is final: retire it into the low half.
                    lo_d[count_q] = row_sum[0];
                    s_d           = {1'b0, row_sum[WIDTH-1:1]};
                    c_d           = row_carry;
                    count_d       = count_q + CNT_W'(1);
                    if (count_q == LAST_STEP) begin
                        state_d = RESOLVE;
                    end
                end
                RESOLVE: begin
                    product_d = {hi_sum, lo_q};
                    state_d   = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, no matter
        // the order in which the statements are written.
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            c_q       <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            c_q       <= c_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_csa_mult_seq.sv
// Self-checking bench for csa_mult_seq: directed cases plus randomized operands
// compared with plain a*b and a fixed WIDTH+1 edge latency.
module tb_csa_mult_seq;

    localparam int W   = 8;
    localparam int W2  = 2 * W;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W2-1:0] product;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    csa_mult_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and take them through the accepting edge.
    task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        #1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    // Called right after the accepting edge: result must appear exactly LAT edges later.
    task automatic wait_result(input logic [W2-1:0] exp);
        for (int i = 0; i < LAT; i++) begin
            check("in_ready_while_busy", 32'(in_ready), 32'd0);
            check("busy_while_working", 32'(busy), 32'd1);
            check("out_valid_early", 32'(out_valid), 32'd0);
            tick();
        end
        check("out_valid_at_latency", 32'(out_valid), 32'd1);
        check("product", 32'(product), 32'(exp));
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    // Drain the held result and return to IDLE.
    task automatic finish_op();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        check("out_valid_after_drain", 32'(out_valid), 32'd0);
        check("in_ready_after_drain", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int            da [4];
        int            db [4];
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [W2-1:0] last_exp;
        bit            in_done;
        bit            accepted;
        int            waited;

        rst_n     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state.
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed products with the consumer always ready.
        out_ready = 1'b1;
        da = '{13, 255, 0, 1};
        db = '{11, 255, 200, 128};
        for (int i = 0; i < 4; i++) begin
            start_op(W'(da[i]), W'(db[i]));
            wait_result(W2'(da[i] * db[i]));
            finish_op();
        end

        // Backpressure: result held while out_ready is low, then back-to-back accept.
        out_ready = 1'b0;
        start_op(8'd7, 8'd9);
        wait_result(16'd63);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            check("bp_product_held", 32'(product), 32'd63);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        start_op(8'd3, 8'd5);
        wait_result(16'd15);
        finish_op();

        // Abort in ACCUM step 4: back to IDLE, no result, product unchanged.
        start_op(8'd100, 8'd100);
        repeat (4) tick();
        abort    = 1'b1;
        in_valid = 1'b1;
        a        = 8'd1;
        b        = 8'd1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_product_kept", 32'(product), 32'd15);
        for (int i = 0; i < 12; i++) begin
            check("abort_no_result", 32'(out_valid), 32'd0);
            tick();
        end

        // Abort in IDLE overrides a simultaneous handshake.
        abort    = 1'b1;
        in_valid = 1'b1;
        a        = 8'd5;
        b        = 8'd5;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_ignores_accept", 32'(busy), 32'd0);

        start_op(8'd2, 8'd3);
        wait_result(16'd6);
        finish_op();

        // Reset while in RESOLVE clears the product and the result never appears.
        start_op(8'd9, 8'd9);
        repeat (W) tick();
        check("resolve_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rst_resolve_out_valid", 32'(out_valid), 32'd0);
        check("rst_resolve_product", 32'(product), 32'd0);
        check("rst_resolve_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        check("rst_resolve_in_ready", 32'(in_ready), 32'd1);

        // Random operands, random consumer backpressure, occasional idle gaps.
        in_done  = 1'b0;
        last_exp = '0;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 7))
                0:       ra = '0;
                1:       ra = '1;
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = '1;
                default: rb = W'($urandom);
            endcase

            if (in_done && $urandom_range(0, 3) == 0) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
                tick();
                check("rand_drain_out_valid", 32'(out_valid), 32'd0);
                in_done = 1'b0;
            end

            a        = ra;
            b        = rb;
            in_valid = 1'b1;
            accepted = 1'b0;
            waited   = 0;
            while (!accepted && waited < 64) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (in_done) begin
                    check("rand_held_valid", 32'(out_valid), 32'd1);
                    check("rand_held_product", 32'(product), 32'(last_exp));
                end
                if (in_ready) accepted = 1'b1;
                tick();
                waited++;
            end
            if (!accepted) begin
                check("rand_accept_timeout", 32'(accepted), 32'd1);
                break;
            end
            in_valid = 1'b0;
            a        = W'($urandom);
            b        = W'($urandom);
            last_exp = W2'(ra) * W2'(rb);
            wait_result(last_exp);
            in_done = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
